prog_loader: RTL and testbench

Byte-stream program loader that fills the CPU's instruction and data memories before execution and then releases the core from reset. It sits in TOP between an external byte source (UART RX or a bench driver) and the write ports of instruction memory and data memory. It also gates the CPU's reset. It is the writing end of the memories the single-cycle CPU reads, so programs such as factorial and bubble sort can be loaded without rebuilding memory init files.

---
 rtl/prog_loader_if.sv | 35 +++
 rtl/prog_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Stream-in / memory-write-out bundle for the program loader.
// Handshake: a byte moves from source to loader on a rising clk edge where
// in_valid && in_ready are both high; in_data must be stable while in_valid
// is high. The memory write ports have no ready: imem_we/dmem_we are
// single-cycle strobes and the memories must take the write that cycle.
interface prog_loader_if #(
  parameter int INST_ADDR_W = 8,
  parameter int DATA_ADDR_W = 8
) ();
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   imem_we;
  logic [INST_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_wdata;
  logic                   dmem_we;
  logic [DATA_ADDR_W-1:0] dmem_addr;
  logic [63:0]            dmem_wdata;

  // Loader side: consumes the byte stream, drives the memory write ports.
  modport master (
    input  in_data, in_valid,
    output in_ready,
    output imem_we, imem_addr, imem_wdata,
    output dmem_we, dmem_addr, dmem_wdata
  );

  // Environment side: byte source plus the memories' write ports.
  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  imem_we, imem_addr, imem_wdata,
    input  dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses command frames, writes assembled
// little-endian words into instruction/data memory, and gates CPU reset
// (GO releases the core, HALT puts it back into reset).
module prog_loader #(
  parameter int INST_ADDR_W = 8,
  parameter int DATA_ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.master bus,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          err,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNT_LO  = 3'd1,
    S_CNT_HI  = 3'd2,
    S_ADR_LO  = 3'd3,
    S_ADR_HI  = 3'd4,
    S_PAYLOAD = 3'd5,
    S_RUN     = 3'd6
  } state_t;

  localparam logic [7:0] CMD_INST = 8'h01;
  localparam logic [7:0] CMD_DATA = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'hFF;
  localparam logic [7:0] CMD_HALT = 8'h00;

  state_t                 r_state;
  state_t                 w_state_next;

  logic                   r_in_ready;
  logic                   r_tgt_data;   // 1: current frame targets data memory
  logic [15:0]            r_count;      // words still to be written
  logic [7:0]             r_adr_lo;
  logic [2:0]             r_lane;       // byte lane within the word being assembled
  logic [63:0]            r_asm;

  logic                   r_imem_we;
  logic [INST_ADDR_W-1:0] r_imem_addr;
  logic [31:0]            r_imem_wdata;
  logic                   r_dmem_we;
  logic [DATA_ADDR_W-1:0] r_dmem_addr;
  logic [63:0]            r_dmem_wdata;
  logic                   r_cpu_rst_n;
  logic                   r_busy;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_frame_start;
  logic                   w_go;
  logic                   w_halt;
  logic                   w_bad;
  logic                   w_last_byte;
  logic [63:0]            w_asm_next;

  assign w_accept = bus.in_valid && r_in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus one-cycle event flags for the datapath.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_go          = 1'b0;
    w_halt        = 1'b0;
    w_bad         = 1'b0;
    w_last_byte   = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_data == CMD_INST || bus.in_data == CMD_DATA) begin
            w_state_next  = S_CNT_LO;
            w_frame_start = 1'b1;
          end else if (bus.in_data == CMD_GO) begin
            w_state_next = S_RUN;
            w_go         = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
        S_CNT_LO: w_state_next = S_CNT_HI;
        S_CNT_HI: w_state_next = S_ADR_LO;
        S_ADR_LO: w_state_next = S_ADR_HI;
        S_ADR_HI: begin
          // A zero-length frame carries no payload at all.
          w_state_next = (r_count == 16'd0) ? S_IDLE : S_PAYLOAD;
        end
        S_PAYLOAD: begin
          w_last_byte = r_tgt_data ? (r_lane == 3'd7) : (r_lane[1:0] == 2'd3);
          // Leave on the final byte so the next command byte can be taken
          // during the final strobe cycle.
          if (w_last_byte && r_count == 16'd1) begin
            w_state_next = S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.in_data == CMD_HALT) begin
            w_state_next = S_IDLE;
            w_halt       = 1'b1;
          end else begin
            w_bad = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Assembly register with the incoming byte dropped into its lane.
  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_lane, 3'b000} +: 8] = bus.in_data;
  end

  // Datapath: header capture, word assembly, write strobes, reset gating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_tgt_data   <= 1'b0;
      r_count      <= 16'd0;
      r_adr_lo     <= 8'd0;
      r_lane       <= 3'd0;
      r_asm        <= 64'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= 64'd0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      r_imem_we  <= 1'b0;
      r_dmem_we  <= 1'b0;

      // Address and remaining count advance once the strobe has been seen.
      if (r_imem_we) begin
        r_imem_addr <= r_imem_addr + 1'b1;
      end
      if (r_dmem_we) begin
        r_dmem_addr <= r_dmem_addr + 1'b1;
      end
      if (r_imem_we || r_dmem_we) begin
        r_count <= r_count - 16'd1;
      end

      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (w_frame_start) begin
              r_tgt_data <= (bus.in_data == CMD_DATA);
            end
          end
          S_CNT_LO: r_count <= {8'h00, bus.in_data};
          S_CNT_HI: r_count[15:8] <= bus.in_data;
          S_ADR_LO: r_adr_lo <= bus.in_data;
          S_ADR_HI: begin
            if (r_tgt_data) begin
              r_dmem_addr <= DATA_ADDR_W'({bus.in_data, r_adr_lo});
            end else begin
              r_imem_addr <= INST_ADDR_W'({bus.in_data, r_adr_lo});
            end
            r_lane <= 3'd0;
            r_asm  <= 64'd0;
          end
          S_PAYLOAD: begin
            r_asm <= w_asm_next;
            if (w_last_byte) begin
              r_lane <= 3'd0;
              if (r_tgt_data) begin
                r_dmem_we    <= 1'b1;
                r_dmem_wdata <= w_asm_next;
              end else begin
                r_imem_we    <= 1'b1;
                r_imem_wdata <= w_asm_next[31:0];
              end
            end else begin
              r_lane <= r_lane + 3'd1;
            end
          end
          default: ;
        endcase
      end

      if (w_go) begin
        r_cpu_rst_n <= 1'b1;
      end else if (w_halt) begin
        r_cpu_rst_n <= 1'b0;
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
      r_busy <= (w_state_next != S_IDLE) && (w_state_next != S_RUN);
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign cpu_rst_n      = r_cpu_rst_n;
  assign busy           = r_busy;
  assign err            = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a per-cycle vector table for the basic load and
// GO/HALT flow, hand sequences for wrap, zero count, stalls and mid-frame
// reset, then random frames checked by a write scoreboard.
module tb_prog_loader;

  localparam int SBW = 73;  // {is_data, addr[7:0], wdata[63:0]}

  logic       clk;
  logic       rst_n;
  logic       cpu_rst_n;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;

  prog_loader_if #(.INST_ADDR_W(8), .DATA_ADDR_W(8)) bus ();

  prog_loader #(.INST_ADDR_W(8), .DATA_ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic sb_en = 1'b0;
  logic [SBW-1:0] exp_q[$];
  logic [63:0] fw[16];

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        iwe;
    logic [7:0]  ia;
    logic [31:0] iwd;
    logic        dwe;
    logic [7:0]  da;
    logic [63:0] dwd;
    logic        cpu;
    logic        bsy;
    logic        er;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one edge, optionally after idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) tick();
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Reference model: word i of a frame lands at (start + i) mod 256.
  task automatic model_frame(input logic tgt, input int cnt, input int addr16);
    for (int i = 0; i < cnt; i++) begin
      logic [7:0]  a;
      logic [63:0] w;
      a = 8'((addr16 + i) % 256);
      w = tgt ? fw[i] : {32'h0, fw[i][31:0]};
      exp_q.push_back({tgt, a, w});
    end
  endtask

  // Byte-level frame driver: header then little-endian payload from fw[].
  task automatic send_frame(input logic tgt, input int cnt, input int addr16, input int max_gap);
    int nb;
    logic [15:0] c16;
    logic [15:0] a16;
    nb  = tgt ? 8 : 4;
    c16 = 16'(cnt);
    a16 = 16'(addr16);
    send(tgt ? 8'h02 : 8'h01, 0);
    send(c16[7:0], $urandom_range(0, max_gap));
    send(c16[15:8], $urandom_range(0, max_gap));
    send(a16[7:0], $urandom_range(0, max_gap));
    send(a16[15:8], $urandom_range(0, max_gap));
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < nb; k++) begin
        logic [63:0] w;
        w = fw[i];
        send(w[8*k +: 8], $urandom_range(0, max_gap));
      end
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic iwe, input logic [7:0] ia,
                     input logic [31:0] iwd, input logic dwe, input logic [7:0] da,
                     input logic [63:0] dwd, input logic cpu, input logic bsy, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.iwe = iwe; t.ia = ia; t.iwd = iwd; t.dwe = dwe;
    t.da = da; t.dwd = dwd; t.cpu = cpu; t.bsy = bsy; t.er = er;
    tv.push_back(t);
  endtask

  // Scoreboard: every strobe seen must match the oldest expected write.
  always @(negedge clk) begin
    if (sb_en) begin
      if (bus.imem_we) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL imem_strobe: unexpected write addr %h data %h", bus.imem_addr, bus.imem_wdata);
        end else begin
          logic [SBW-1:0] e;
          e = exp_q.pop_front();
          if (e !== {1'b0, bus.imem_addr, 32'h0, bus.imem_wdata}) begin
            n_err++;
            $display("FAIL imem_strobe: got addr %h data %h expected %h", bus.imem_addr, bus.imem_wdata, e);
          end
        end
      end
      if (bus.dmem_we) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dmem_strobe: unexpected write addr %h data %h", bus.dmem_addr, bus.dmem_wdata);
        end else begin
          logic [SBW-1:0] e;
          e = exp_q.pop_front();
          if (e !== {1'b1, bus.dmem_addr, bus.dmem_wdata}) begin
            n_err++;
            $display("FAIL dmem_strobe: got addr %h data %h expected %h", bus.dmem_addr, bus.dmem_wdata, e);
          end
        end
      end
    end
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    tick();
    chk("reset_outputs",
        {bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.dmem_we, bus.dmem_addr,
         bus.dmem_wdata, cpu_rst_n, busy, err}, '0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_reset", bus.in_ready, 1);

    // Per-cycle table: instruction load, GO/HALT, bad header, data load.
    add(1, 8'h01, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h09, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'h40, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 8'hF8, 1, 0, 32'hF8400009, 0, 0, 0, 0, 1, 0);
    add(1, 8'h09, 0, 1, 32'hF8400009, 0, 0, 0, 0, 1, 0);
    add(1, 8'h80, 0, 1, 32'hF8400009, 0, 0, 0, 0, 1, 0);
    add(1, 8'h40, 0, 1, 32'hF8400009, 0, 0, 0, 0, 1, 0);
    add(1, 8'hF8, 1, 1, 32'hF8408009, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 2, 32'hF8408009, 0, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 2, 32'hF8408009, 0, 0, 0, 1, 0, 0);
    add(1, 8'h37, 0, 2, 32'hF8408009, 0, 0, 0, 1, 0, 1);
    add(1, 8'h00, 0, 2, 32'hF8408009, 0, 0, 0, 0, 0, 1);
    add(1, 8'h55, 0, 2, 32'hF8408009, 0, 0, 0, 0, 0, 1);
    add(1, 8'h02, 0, 2, 32'hF8408009, 0, 0, 0, 0, 1, 1);
    add(1, 8'h01, 0, 2, 32'hF8408009, 0, 0, 0, 0, 1, 1);
    add(1, 8'h00, 0, 2, 32'hF8408009, 0, 0, 0, 0, 1, 1);
    add(1, 8'h05, 0, 2, 32'hF8408009, 0, 0, 0, 0, 1, 1);
    add(1, 8'h00, 0, 2, 32'hF8408009, 0, 5, 0, 0, 1, 1);
    add(1, 8'h99, 0, 2, 32'hF8408009, 0, 5, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) add(1, 8'h00, 0, 2, 32'hF8408009, 0, 5, 0, 0, 1, 1);
    add(1, 8'h00, 0, 2, 32'hF8408009, 1, 5, 64'h99, 0, 0, 1);
    add(0, 8'h00, 0, 2, 32'hF8408009, 0, 6, 64'h99, 0, 0, 1);

    for (int i = 0; i < tv.size(); i++) begin
      bus.in_data  = tv[i].d;
      bus.in_valid = tv[i].v;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("table[%0d]", i),
          {bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata,
           cpu_rst_n, busy, err},
          {tv[i].iwe, tv[i].ia, tv[i].iwd, tv[i].dwe, tv[i].da, tv[i].dwd,
           tv[i].cpu, tv[i].bsy, tv[i].er});
    end

    sb_en = 1'b1;

    // Address wrap: two instruction words starting at 0xFF.
    fw[0] = 64'h0000_0000_1111_2222;
    fw[1] = 64'h0000_0000_3333_4444;
    model_frame(1'b0, 2, 16'h00FF);
    send_frame(1'b0, 2, 16'h00FF, 0);
    tick();
    tick();
    chk("wrap_drained", exp_q.size(), 0);

    // Zero count: no strobe, back in IDLE.
    send_frame(1'b0, 0, 16'h0003, 0);
    tick();
    chk("zero_count_busy", busy, 0);

    // Stall: in_valid toggles every cycle through the frame.
    fw[0] = 64'h0123_4567_89AB_CDEF;
    fw[1] = 64'hFEDC_BA98_7654_3210;
    model_frame(1'b1, 2, 16'h1240);
    for (int i = 0; i < 5; i++) begin end
    send(8'h02, 1); send(8'h02, 1); send(8'h00, 1); send(8'h40, 1); send(8'h12, 1);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) begin
        logic [63:0] w;
        w = fw[i];
        send(w[8*k +: 8], 1);
      end
    tick();
    tick();
    chk("stall_drained", exp_q.size(), 0);

    // Reset mid-frame after two of four payload bytes.
    send(8'h01, 0); send(8'h01, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'hAA, 0); send(8'hBB, 0);
    rst_n = 1'b0;
    tick();
    chk("midframe_reset_outputs",
        {bus.in_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.dmem_we, bus.dmem_addr,
         bus.dmem_wdata, cpu_rst_n, busy, err}, '0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_midframe_reset", bus.in_ready, 1);
    tick();
    chk("midframe_no_strobe", exp_q.size(), 0);

    // Fresh frame after the aborted one.
    fw[0] = 64'h0000_0000_CAFE_F00D;
    model_frame(1'b0, 1, 16'h0020);
    send_frame(1'b0, 1, 16'h0020, 0);
    tick();
    tick();
    chk("fresh_frame_drained", exp_q.size(), 0);

    // Random frames with random gaps, targets, counts and 16-bit addresses.
    for (int f = 0; f < 20; f++) begin
      logic tgt;
      int cnt;
      int adr;
      tgt = 1'($urandom_range(0, 1));
      cnt = $urandom_range(1, 4);
      adr = (f % 5 == 0) ? $urandom_range(253, 255) : $urandom_range(0, 65535);
      for (int i = 0; i < cnt; i++) fw[i] = {$urandom, $urandom};
      model_frame(tgt, cnt, adr);
      send_frame(tgt, cnt, adr, (f % 2 == 0) ? 0 : 2);
    end
    for (int i = 0; i < 3; i++) tick();
    chk("random_drained", exp_q.size(), 0);
    chk("random_end_busy", busy, 0);

    // GO then HALT once more through the random-phase state.
    send(8'hFF, 0);
    chk("go_cpu_rst_n", cpu_rst_n, 1);
    send(8'h00, 0);
    chk("halt_cpu_rst_n", cpu_rst_n, 0);

    sb_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, stopping");
    $fatal(1, "timeout");
  end

endmodule
